// File: rtl/nco_sweep_pkg.sv
// Shared definitions for the NCO frequency-sweep controller: default widths
// and the sweep state encoding.
package nco_sweep_pkg;

    localparam int APR     = 13;
    localparam int DWELL_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2
    } sweep_state_t;

endpackage

// File: rtl/nco_dwell_cnt.sv
// Loadable dwell down-counter. Decrements only on enabled cycles and keeps a
// registered zero flag so the sweep FSM never sees a compare path.
module nco_dwell_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clken,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    import nco_sweep_pkg::*;

    logic [W-1:0] count;

    // Load has priority over counting; the counter parks at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            zero  <= 1'b1;
        end else if (load) begin
            count <= load_val;
            zero  <= (load_val == '0);
        end else if (en && clken && !zero) begin
            count <= count - W'(1);
            zero  <= (count == W'(1));
        end
    end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep controller producing the NCO phase-increment word as a
// stepped linear ramp from f_start to f_stop, single-shot or continuous.
module nco_sweep_ctrl #(
    parameter int APR     = nco_sweep_pkg::APR,
    parameter int DWELL_W = nco_sweep_pkg::DWELL_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clken,
    input  logic               start,
    input  logic               abort,
    input  logic               continuous,
    input  logic [APR-1:0]     f_start,
    input  logic [APR-1:0]     f_stop,
    input  logic [APR-1:0]     f_step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [APR-1:0]     phi_inc_o,
    output logic               busy,
    output logic               step_strobe,
    output logic               done,
    output logic [1:0]         dbg_state
);
    import nco_sweep_pkg::*;

    sweep_state_t state, state_nxt;

    logic [APR-1:0]     start_q, stop_q, step_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               cont_q;

    logic [APR-1:0]     phi_nxt;
    logic               busy_nxt, strobe_nxt, done_nxt;
    logic               latch_cfg;
    logic               cnt_load, cnt_zero;
    logic [DWELL_W-1:0] cnt_val;

    // One extra bit so the step can overshoot f_stop without wrapping.
    logic [APR:0] sum;
    assign sum = {1'b0, phi_inc_o} + {1'b0, step_q};

    assign dbg_state = state;

    nco_dwell_cnt #(.W(DWELL_W)) u_dwell (
        .clk      (clk),
        .reset    (reset),
        .clken    (clken),
        .en       (state != IDLE),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_nxt  = state;
        phi_nxt    = phi_inc_o;
        busy_nxt   = busy;
        strobe_nxt = 1'b0;
        done_nxt   = 1'b0;
        latch_cfg  = 1'b0;
        cnt_load   = 1'b0;
        cnt_val    = dwell_q;
        if (abort) begin
            state_nxt = IDLE;
            phi_nxt   = '0;
            busy_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        latch_cfg  = 1'b1;
                        phi_nxt    = f_start;
                        cnt_load   = 1'b1;
                        cnt_val    = dwell;
                        busy_nxt   = 1'b1;
                        strobe_nxt = 1'b1;
                        state_nxt  = (f_stop <= f_start) ? LAST : RUN;
                    end
                end
                RUN: begin
                    if (clken && cnt_zero) begin
                        cnt_load   = 1'b1;
                        strobe_nxt = 1'b1;
                        if (sum >= {1'b0, stop_q}) begin
                            phi_nxt   = stop_q;
                            state_nxt = LAST;
                        end else begin
                            phi_nxt = sum[APR-1:0];
                        end
                    end
                end
                LAST: begin
                    if (clken && cnt_zero) begin
                        done_nxt = 1'b1;
                        if (cont_q) begin
                            phi_nxt    = start_q;
                            cnt_load   = 1'b1;
                            strobe_nxt = 1'b1;
                            state_nxt  = (stop_q <= start_q) ? LAST : RUN;
                        end else begin
                            // Single-shot: the final word stays on the NCO.
                            state_nxt = IDLE;
                            busy_nxt  = 1'b0;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    phi_nxt   = '0;
                    busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            phi_inc_o   <= '0;
            busy        <= 1'b0;
            step_strobe <= 1'b0;
            done        <= 1'b0;
            start_q     <= '0;
            stop_q      <= '0;
            step_q      <= '0;
            dwell_q     <= '0;
            cont_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            phi_inc_o   <= phi_nxt;
            busy        <= busy_nxt;
            step_strobe <= strobe_nxt;
            done        <= done_nxt;
            if (latch_cfg) begin
                start_q <= f_start;
                stop_q  <= f_stop;
                step_q  <= f_step;
                dwell_q <= dwell;
                cont_q  <= continuous;
            end
        end
    end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: a word-list reference model (sweep words plus
// enabled-cycle dwell accounting) checked every cycle, with fixed spot values.
module tb_nco_sweep_ctrl;

    logic        clk = 1'b0;
    logic        reset, clken, start, abort, continuous;
    logic [12:0] f_start, f_stop, f_step;
    logic [15:0] dwell;
    logic [12:0] phi_inc_o;
    logic        busy, step_strobe, done;
    logic [1:0]  dbg_state;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int          m_words[$];
    bit          m_endless, m_cont, m_active;
    int          m_dwell, m_idx, m_held;
    logic [12:0] m_phi;
    logic        m_busy, m_strobe, m_done;

    always #5 clk = ~clk;

    nco_sweep_ctrl #(.APR(13), .DWELL_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .clken       (clken),
        .start       (start),
        .abort       (abort),
        .continuous  (continuous),
        .f_start     (f_start),
        .f_stop      (f_stop),
        .f_step      (f_step),
        .dwell       (dwell),
        .phi_inc_o   (phi_inc_o),
        .busy        (busy),
        .step_strobe (step_strobe),
        .done        (done),
        .dbg_state   (dbg_state)
    );

    task automatic model_reset();
        m_active = 0;
        m_phi    = '0;
        m_busy   = 0;
        m_strobe = 0;
        m_done   = 0;
    endtask

    // Applies the inputs present at a rising edge to the model.
    task automatic model_edge();
        int w;
        m_strobe = 0;
        m_done   = 0;
        if (abort) begin
            m_active = 0;
            m_phi    = '0;
            m_busy   = 0;
        end else if (!m_active) begin
            if (start) begin
                m_words.delete();
                w = int'(f_start);
                m_words.push_back(w);
                m_endless = (int'(f_stop) > w) && (f_step == 0);
                if (!m_endless) begin
                    while (w < int'(f_stop)) begin
                        w = w + int'(f_step);
                        m_words.push_back((w >= int'(f_stop)) ? int'(f_stop) : w);
                    end
                end
                m_cont   = continuous;
                m_dwell  = int'(dwell);
                m_idx    = 0;
                m_held   = 0;
                m_active = 1;
                m_busy   = 1;
                m_strobe = 1;
                m_phi    = 13'(m_words[0]);
            end
        end else if (clken) begin
            m_held++;
            if (m_held == m_dwell + 1) begin
                m_held = 0;
                if (m_endless) begin
                    m_strobe = 1;
                end else if (m_idx < m_words.size() - 1) begin
                    m_idx++;
                    m_phi    = 13'(m_words[m_idx]);
                    m_strobe = 1;
                end else begin
                    m_done = 1;
                    if (m_cont) begin
                        m_idx    = 0;
                        m_phi    = 13'(m_words[0]);
                        m_strobe = 1;
                    end else begin
                        m_active = 0;
                        m_busy   = 0;
                    end
                end
            end
        end
    endtask

    // Advance one clock: model follows the edge, outputs sampled at negedge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic configure(input int fs, input int fp, input int st, input int dw, input bit cont);
        f_start    = 13'(fs);
        f_step     = 13'(fp);
        f_stop     = 13'(st);
        dwell      = 16'(dw);
        continuous = cont;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 0; abort = 0; clken = 1; continuous = 0;
        configure(0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({phi_inc_o, busy, step_strobe, done} !== {13'd0, 3'b000}) begin
            miscompares++;
            $display("FAIL reset_values: got phi=%0d busy=%0b strobe=%0b done=%0b, want all 0",
                     phi_inc_o, busy, step_strobe, done);
        end
        reset = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            cycle();
            vectors++;
            if ({phi_inc_o, busy, step_strobe, done} !== {m_phi, m_busy, m_strobe, m_done}) begin
                miscompares++;
                $display("FAIL reset_idle cyc %0d: got phi=%0d busy=%0b strobe=%0b done=%0b, want phi=%0d busy=%0b strobe=%0b done=%0b",
                         n, phi_inc_o, busy, step_strobe, done, m_phi, m_busy, m_strobe, m_done);
            end
        end
    endtask

    task automatic test_single_shot();
        int e_phi; bit e_busy, e_done, sp;
        configure(100, 50, 300, 3, 0);
        start = 1;
        for (int n = 1; n <= 23; n++) begin
            cycle();
            start = 0;
            vectors++;
            if ({phi_inc_o, busy, step_strobe, done} !== {m_phi, m_busy, m_strobe, m_done}) begin
                miscompares++;
                $display("FAIL single_shot cyc %0d: got phi=%0d busy=%0b strobe=%0b done=%0b, want phi=%0d busy=%0b strobe=%0b done=%0b",
                         n, phi_inc_o, busy, step_strobe, done, m_phi, m_busy, m_strobe, m_done);
            end
            sp = 1; e_busy = 1; e_done = 0; e_phi = 0;
            case (n)
                1, 4:   e_phi = 100;
                5:      e_phi = 150;
                9:      e_phi = 200;
                13:     e_phi = 250;
                17, 20: e_phi = 300;
                21:     begin e_phi = 300; e_busy = 0; e_done = 1; end
                22:     begin e_phi = 300; e_busy = 0; end
                default: sp = 0;
            endcase
            if (sp) begin
                vectors++;
                if (int'(phi_inc_o) != e_phi || busy !== e_busy || done !== e_done) begin
                    miscompares++;
                    $display("FAIL single_shot_spot cyc %0d: got phi=%0d busy=%0b done=%0b, want phi=%0d busy=%0b done=%0b",
                             n, phi_inc_o, busy, done, e_phi, e_busy, e_done);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int e_phi; bit e_busy, e_done, sp;
        configure(8000, 500, 8191, 0, 0);
        start = 1;
        for (int n = 1; n <= 5; n++) begin
            cycle();
            start = 0;
            vectors++;
            if ({phi_inc_o, busy, step_strobe, done} !== {m_phi, m_busy, m_strobe, m_done}) begin
                miscompares++;
                $display("FAIL saturation cyc %0d: got phi=%0d busy=%0b strobe=%0b done=%0b, want phi=%0d busy=%0b strobe=%0b done=%0b",
                         n, phi_inc_o, busy, step_strobe, done, m_phi, m_busy, m_strobe, m_done);
            end
            sp = 1; e_busy = 1; e_done = 0; e_phi = 0;
            case (n)
                1: e_phi = 8000;
                2: e_phi = 8191;
                3: begin e_phi = 8191; e_busy = 0; e_done = 1; end
                default: sp = 0;
            endcase
            if (sp) begin
                vectors++;
                if (int'(phi_inc_o) != e_phi || busy !== e_busy || done !== e_done) begin
                    miscompares++;
                    $display("FAIL saturation_spot cyc %0d: got phi=%0d busy=%0b done=%0b, want phi=%0d busy=%0b done=%0b",
                             n, phi_inc_o, busy, done, e_phi, e_busy, e_done);
                end
            end
        end
    endtask

    task automatic test_continuous();
        int e_phi; bit e_busy, e_done, sp;
        configure(100, 50, 300, 3, 1);
        start = 1;
        for (int n = 1; n <= 33; n++) begin
            cycle();
            start = 0;
            abort = (n == 30);
            vectors++;
            if ({phi_inc_o, busy, step_strobe, done} !== {m_phi, m_busy, m_strobe, m_done}) begin
                miscompares++;
                $display("FAIL continuous cyc %0d: got phi=%0d busy=%0b strobe=%0b done=%0b, want phi=%0d busy=%0b strobe=%0b done=%0b",
                         n, phi_inc_o, busy, step_strobe, done, m_phi, m_busy, m_strobe, m_done);
            end
            sp = 1; e_busy = 1; e_done = 0; e_phi = 0;
            case (n)
                17:     e_phi = 300;
                21:     begin e_phi = 100; e_done = 1; end
                25:     e_phi = 150;
                31, 32: e_busy = 0;
                default: sp = 0;
            endcase
            if (sp) begin
                vectors++;
                if (int'(phi_inc_o) != e_phi || busy !== e_busy || done !== e_done) begin
                    miscompares++;
                    $display("FAIL continuous_spot cyc %0d: got phi=%0d busy=%0b done=%0b, want phi=%0d busy=%0b done=%0b",
                             n, phi_inc_o, busy, done, e_phi, e_busy, e_done);
                end
            end
        end
        abort = 0;
    endtask

    task automatic test_clken_half();
        int e_phi; bit e_busy, e_done, sp;
        configure(1000, 10, 1030, 1, 0);
        clken = 0;
        start = 1;
        for (int n = 1; n <= 18; n++) begin
            cycle();
            start = 0;
            clken = n[0];
            vectors++;
            if ({phi_inc_o, busy, step_strobe, done} !== {m_phi, m_busy, m_strobe, m_done}) begin
                miscompares++;
                $display("FAIL clken_half cyc %0d: got phi=%0d busy=%0b strobe=%0b done=%0b, want phi=%0d busy=%0b strobe=%0b done=%0b",
                         n, phi_inc_o, busy, step_strobe, done, m_phi, m_busy, m_strobe, m_done);
            end
            sp = 1; e_busy = 1; e_done = 0; e_phi = 0;
            case (n)
                1, 3:   e_phi = 1000;
                4, 7:   e_phi = 1010;
                8, 11:  e_phi = 1020;
                12, 15: e_phi = 1030;
                16:     begin e_phi = 1030; e_busy = 0; e_done = 1; end
                default: sp = 0;
            endcase
            if (sp) begin
                vectors++;
                if (int'(phi_inc_o) != e_phi || busy !== e_busy || done !== e_done) begin
                    miscompares++;
                    $display("FAIL clken_half_spot cyc %0d: got phi=%0d busy=%0b done=%0b, want phi=%0d busy=%0b done=%0b",
                             n, phi_inc_o, busy, done, e_phi, e_busy, e_done);
                end
            end
        end
        clken = 1;
    endtask

    task automatic test_edge_cases();
        int e_phi; bit e_busy, e_done, sp;
        // f_stop == f_start: a single held word
        configure(77, 5, 77, 2, 0);
        start = 1;
        for (int n = 1; n <= 5; n++) begin
            cycle();
            start = 0;
            vectors++;
            if ({phi_inc_o, busy, step_strobe, done} !== {m_phi, m_busy, m_strobe, m_done}) begin
                miscompares++;
                $display("FAIL equal_ends cyc %0d: got phi=%0d busy=%0b strobe=%0b done=%0b, want phi=%0d busy=%0b strobe=%0b done=%0b",
                         n, phi_inc_o, busy, step_strobe, done, m_phi, m_busy, m_strobe, m_done);
            end
            sp = 1; e_phi = 77; e_busy = (n <= 3); e_done = (n == 4);
            if (n == 5) sp = 0;
            if (sp) begin
                vectors++;
                if (int'(phi_inc_o) != e_phi || busy !== e_busy || done !== e_done) begin
                    miscompares++;
                    $display("FAIL equal_ends_spot cyc %0d: got phi=%0d busy=%0b done=%0b, want phi=%0d busy=%0b done=%0b",
                             n, phi_inc_o, busy, done, e_phi, e_busy, e_done);
                end
            end
        end
        // start and abort together: abort wins
        configure(400, 10, 500, 0, 0);
        start = 1;
        abort = 1;
        for (int n = 1; n <= 3; n++) begin
            cycle();
            start = 0;
            abort = 0;
            vectors++;
            if ({phi_inc_o, busy, step_strobe, done} !== {13'd0, 3'b000}
                || {phi_inc_o, busy} !== {m_phi, m_busy}) begin
                miscompares++;
                $display("FAIL start_abort cyc %0d: got phi=%0d busy=%0b strobe=%0b done=%0b, want phi=0 busy=0 strobe=0 done=0",
                         n, phi_inc_o, busy, step_strobe, done);
            end
        end
        // start while busy: second request and config change ignored
        configure(200, 100, 600, 1, 0);
        start = 1;
        for (int n = 1; n <= 13; n++) begin
            cycle();
            start = (n == 2);
            if (n == 2) configure(5000, 7, 5100, 0, 1);
            vectors++;
            if ({phi_inc_o, busy, step_strobe, done} !== {m_phi, m_busy, m_strobe, m_done}) begin
                miscompares++;
                $display("FAIL start_busy cyc %0d: got phi=%0d busy=%0b strobe=%0b done=%0b, want phi=%0d busy=%0b strobe=%0b done=%0b",
                         n, phi_inc_o, busy, step_strobe, done, m_phi, m_busy, m_strobe, m_done);
            end
            sp = 1; e_busy = 1; e_done = 0; e_phi = 0;
            case (n)
                3:  e_phi = 300;
                9:  e_phi = 600;
                11: begin e_phi = 600; e_busy = 0; e_done = 1; end
                default: sp = 0;
            endcase
            if (sp) begin
                vectors++;
                if (int'(phi_inc_o) != e_phi || busy !== e_busy || done !== e_done) begin
                    miscompares++;
                    $display("FAIL start_busy_spot cyc %0d: got phi=%0d busy=%0b done=%0b, want phi=%0d busy=%0b done=%0b",
                             n, phi_inc_o, busy, done, e_phi, e_busy, e_done);
                end
            end
        end
        start = 0;
    endtask

    task automatic test_reset_mid();
        configure(100, 50, 300, 3, 1);
        start = 1;
        for (int n = 1; n <= 6; n++) begin
            cycle();
            start = 0;
            vectors++;
            if ({phi_inc_o, busy, step_strobe, done} !== {m_phi, m_busy, m_strobe, m_done}) begin
                miscompares++;
                $display("FAIL reset_mid_pre cyc %0d: got phi=%0d busy=%0b strobe=%0b done=%0b, want phi=%0d busy=%0b strobe=%0b done=%0b",
                         n, phi_inc_o, busy, step_strobe, done, m_phi, m_busy, m_strobe, m_done);
            end
        end
        #2 reset = 1'b1;
        #1;
        model_reset();
        vectors++;
        if ({phi_inc_o, busy, step_strobe, done} !== {13'd0, 3'b000}) begin
            miscompares++;
            $display("FAIL reset_async: got phi=%0d busy=%0b strobe=%0b done=%0b, want all 0",
                     phi_inc_o, busy, step_strobe, done);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            cycle();
            vectors++;
            if ({phi_inc_o, busy, step_strobe, done} !== {13'd0, 3'b000}
                || {phi_inc_o, busy, done} !== {m_phi, m_busy, m_done}) begin
                miscompares++;
                $display("FAIL reset_mid_post cyc %0d: got phi=%0d busy=%0b strobe=%0b done=%0b, want all 0",
                         n, phi_inc_o, busy, step_strobe, done);
            end
        end
    endtask

    task automatic test_random();
        for (int cfg = 0; cfg < 12; cfg++) begin
            for (int n = 1; n <= 150; n++) begin
                if (n == 1 || $urandom_range(0, 9) == 0) begin
                    configure(int'($urandom_range(0, 8191)),
                              ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 2500)),
                              int'($urandom_range(0, 8191)),
                              int'($urandom_range(0, 3)),
                              $urandom_range(0, 1) == 1);
                end
                start = ($urandom_range(0, 12) == 0);
                abort = ($urandom_range(0, 60) == 0);
                clken = ($urandom_range(0, 3) != 0);
                cycle();
                vectors++;
                if ({phi_inc_o, busy, step_strobe, done} !== {m_phi, m_busy, m_strobe, m_done}) begin
                    miscompares++;
                    $display("FAIL random cfg %0d cyc %0d: got phi=%0d busy=%0b strobe=%0b done=%0b, want phi=%0d busy=%0b strobe=%0b done=%0b",
                             cfg, n, phi_inc_o, busy, step_strobe, done, m_phi, m_busy, m_strobe, m_done);
                end
            end
        end
        start = 0;
        clken = 1;
        abort = 1;
        cycle();
        abort = 0;
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_saturation();
        test_continuous();
        test_clken_half();
        test_edge_cases();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
